// File: rtl/pipe_hazard_ctrl_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
//   hz_mode_t        : controller decision mode (RUN, MEMW, RAW, FLUSH)
//   DEF_*            : default latency / flush-length parameters
//   OPC_NOP          : NOP opcode (addi x0,x0,0), shared with decode
//   NUM_REGS         : architectural register count
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      MEMW  = 2'd1,
      RAW   = 2'd2,
      FLUSH = 2'd3
   } hz_mode_t;

   localparam int unsigned DEF_ALU_LAT      = 3;
   localparam int unsigned DEF_LOAD_LAT     = 3;
   localparam int unsigned DEF_FLUSH_CYCLES = 2;
   localparam int unsigned NUM_REGS         = 32;

   localparam logic [6:0] OPC_NOP = 7'b0010011;

endpackage

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// reg_scoreboard: per-register pending-write tracker for x1..x31.
// Each register owns a 2-bit down-counter; a register is busy while its
// counter is nonzero.
//   clk, resetn : clock, asynchronous active-low reset
//   freeze      : hold every counter this cycle (memory wait)
//   set_en      : load counter[set_rd] with set_lat this cycle
//   set_rd      : destination register to mark busy
//   set_lat     : cycles until the result is readable
//   busy_vec    : bit i set while counter i is nonzero; bit 0 always 0
module reg_scoreboard
   import hazard_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        freeze,
   input  logic        set_en,
   input  logic [4:0]  set_rd,
   input  logic [1:0]  set_lat,
   output logic [31:0] busy_vec
);

   logic [1:0] cnt [1:NUM_REGS-1];

   // A load on the issuing register takes precedence over its decrement.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int unsigned i = 1; i < NUM_REGS; i++) begin
            cnt[i] <= '0;
         end
      end else if (!freeze) begin
         for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (set_en && (set_rd == 5'(i))) begin
               cnt[i] <= set_lat;
            end else if (cnt[i] != '0) begin
               cnt[i] <= cnt[i] - 2'd1;
            end
         end
      end
   end

   always_comb begin
      busy_vec = '0;
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
         busy_vec[i] = |cnt[i];
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and sequencing controller beside the decode stage.
// Produces fetch/decode stall, decode flush and EX bubble from a register
// scoreboard (RAW), memory wait, and branch/jump redirects.
// Priority: FLUSH > MEMW > RAW > RUN.
//   clk, resetn              : clock, asynchronous active-low reset
//   id_valid                 : decode holds a valid instruction
//   id_rs1/id_rs2            : source indices; id_uses_rs1/2 qualify them
//   id_rd, id_reg_write      : destination and its write enable
//   id_mem_read              : instruction is a load
//   ex_redirect              : one-cycle taken branch/jump pulse from EX
//   mem_busy                 : data memory not ready, hold the pipeline
//   stall_if, stall_id       : hold PC / IF-ID, decode stall
//   flush_id                 : decode flush
//   bubble_ex                : insert NOP into EX
//   issue                    : instruction leaves ID at this edge
//   busy_vec                 : per-register pending-write flags
// Build option: define HAZARD_FWD_EN when the EX/MEM forwarding network is
// present; only loads then mark the scoreboard, for a single load-use bubble.
module pipe_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned ALU_LAT      = DEF_ALU_LAT,
   parameter int unsigned LOAD_LAT     = DEF_LOAD_LAT,
   parameter int unsigned FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        id_valid,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_uses_rs1,
   input  logic        id_uses_rs2,
   input  logic [4:0]  id_rd,
   input  logic        id_reg_write,
   input  logic        id_mem_read,
   input  logic        ex_redirect,
   input  logic        mem_busy,
   output logic        stall_if,
   output logic        stall_id,
   output logic        flush_id,
   output logic        bubble_ex,
   output logic        issue,
   output logic [31:0] busy_vec
);

   logic [1:0] flush_cnt;
   logic       hazard;
   hz_mode_t   mode;
   logic       sb_set_en;
   logic [1:0] sb_set_lat;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         flush_cnt <= '0;
      end else if (ex_redirect) begin
         flush_cnt <= 2'(FLUSH_CYCLES - 1);
      end else if (flush_cnt != '0) begin
         flush_cnt <= flush_cnt - 2'd1;
      end
   end

   // busy_vec[0] is constant 0, so x0 sources never raise a hazard.
   assign hazard = id_valid &&
                   ((id_uses_rs1 && busy_vec[id_rs1]) ||
                    (id_uses_rs2 && busy_vec[id_rs2]));

   always_comb begin
      if (ex_redirect || (flush_cnt != '0)) mode = FLUSH;
      else if (mem_busy)                     mode = MEMW;
      else if (hazard)                       mode = RAW;
      else                                   mode = RUN;
   end

   // Outputs are gated by resetn so they read as reset values immediately
   // while reset is held, even though ex_redirect/id_valid feed them directly.
   always_comb begin
      stall_if  = 1'b0;
      stall_id  = 1'b0;
      flush_id  = 1'b0;
      bubble_ex = 1'b0;
      issue     = 1'b0;
      if (resetn) begin
         unique case (mode)
            FLUSH: flush_id = 1'b1;
            MEMW: begin
               stall_if = 1'b1;
               stall_id = 1'b1;
            end
            RAW: begin
               stall_if  = 1'b1;
               stall_id  = 1'b1;
               bubble_ex = 1'b1;
            end
            default: issue = id_valid;
         endcase
      end
   end

`ifdef HAZARD_FWD_EN
   assign sb_set_en  = issue && id_reg_write && id_mem_read && (id_rd != '0);
   assign sb_set_lat = 2'd1;
`else
   assign sb_set_en  = issue && id_reg_write && (id_rd != '0);
   assign sb_set_lat = id_mem_read ? 2'(LOAD_LAT) : 2'(ALU_LAT);
`endif

   reg_scoreboard u_scoreboard (
      .clk      (clk),
      .resetn   (resetn),
      .freeze   (mode == MEMW),
      .set_en   (sb_set_en),
      .set_rd   (id_rd),
      .set_lat  (sb_set_lat),
      .busy_vec (busy_vec)
   );

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard and sequencing controller for the in-order RISC-V core. It sits beside the instruction-decode stage and generates that stage's `stall` and `flush` inputs, plus the fetch stall and EX bubble. A per-register scoreboard detects read-after-write hazards, memory-wait freezes the pipeline, and branch/jump redirects are turned into a multi-cycle flush.

## Interface
Parameters:
- `ALU_LAT`, 3: cycles from issue until an ALU result is readable from the register file; range 1..3.
- `LOAD_LAT`, 3: cycles from issue until a load result is readable; range 1..3.
- `FLUSH_CYCLES`, 2: number of cycles `flush_id` stays asserted per redirect; range 1..3.

Ports:
- `clk`  in  1  clock.
- `resetn`  in  1  reset, asynchronous, active-low.
- `id_valid`  in  1  decode stage holds a valid instruction.
- `id_rs1`, `id_rs2`  in  5 each  source register indices.
- `id_uses_rs1`, `id_uses_rs2`  in  1 each  instruction reads that source.
- `id_rd`  in  5  destination register index.
- `id_reg_write`  in  1  instruction writes `id_rd`.
- `id_mem_read`  in  1  instruction is a load.
- `ex_redirect`  in  1  single-cycle pulse: EX resolved a taken branch or jump.
- `mem_busy`  in  1  data memory not ready; the whole pipeline must hold.
- `stall_if`  out  1  hold PC and the IF/ID register.
- `stall_id`  out  1  drives the decode stage `stall` input.
- `flush_id`  out  1  drives the decode stage `flush` input.
- `bubble_ex`  out  1  insert a NOP into EX this cycle.
- `issue`  out  1  instruction leaves ID at this edge.
- `busy_vec`  out  32  bit i set while register i has a pending write; bit 0 is always 0.

## Operation
- Scoreboard: one 2-bit down-counter per register x1..x31. `busy_vec[i]` is 1 when counter i is nonzero.
- `hazard` = `id_valid` and ((`id_uses_rs1` and `busy_vec[id_rs1]`) or (`id_uses_rs2` and `busy_vec[id_rs2]`)). x0 never causes a hazard.
- Decision priority, evaluated combinationally each cycle:
  - **FLUSH** (`ex_redirect` or `flush_cnt` ≠ 0): `flush_id`=1, `stall_if`=0, `stall_id`=0, `bubble_ex`=0, `issue`=0.
  - **MEMW** (`mem_busy`): `stall_if`=1, `stall_id`=1, `bubble_ex`=0, `issue`=0.
  - **RAW** (`hazard`): `stall_if`=1, `stall_id`=1, `bubble_ex`=1, `issue`=0.
  - **RUN**: all four control outputs 0; `issue` = `id_valid`.
- Flush counter:
  - On `ex_redirect`, load `flush_cnt` with `FLUSH_CYCLES`-1.
  - Otherwise, if nonzero, decrement every cycle, including while `mem_busy`.
  - A redirect while `flush_cnt` is nonzero reloads the counter.
- Scoreboard update at each edge:
  - If `mem_busy` and not in FLUSH: all counters hold.
  - Otherwise:
    - Decrement every nonzero counter, saturating at 0.
    - Then, if `issue` and `id_reg_write` and `id_rd` ≠ 0, load counter[`id_rd`] with `LOAD_LAT` when `id_mem_read` is set, else `ALU_LAT`. The load overrides that register's decrement.
- Issue is the only event that sets the scoreboard. Flushed instructions never issue, so they never mark registers busy.

## Timing
- Reset values: `stall_if`=0, `stall_id`=0, `flush_id`=0, `bubble_ex`=0, `issue`=0, `busy_vec`=0. All counters and `flush_cnt` are 0.
- All outputs are combinational from inputs and registered state, with zero-cycle latency. Only the counters are sequential.
- Back-to-back dependent ALU pair, `ALU_LAT`=3:
  - Producer issues at the end of cycle t.
  - Consumer sees counter values 3, 2, 1 in cycles t+1..t+3, so it stalls for 3 bubbles.
  - Consumer issues in cycle t+4.
- Redirect pulsing in cycle t with `FLUSH_CYCLES`=2: `flush_id`=1 in cycles t and t+1, and 0 in t+2.
- If `resetn` is asserted mid-stall or mid-flush, all state clears asynchronously and outputs return to reset values immediately.

## Configuration
- Macro `HAZARD_FWD_EN`. When defined, the EX/MEM forwarding network exists:
  - Non-load writes do not load the scoreboard.
  - Loads load their counter with 1, giving exactly one load-use bubble.
  - `ALU_LAT` and `LOAD_LAT` are ignored.
- When not defined, the scoreboard behaves as described under Operation.

## Structure
- Package `hazard_pkg`:
  - Enum `hz_mode_t` with values RUN, MEMW, RAW, FLUSH.
  - Default latency constants.
  - NOP opcode constant 7'b0010011, shared with decode.
- Sub-module `reg_scoreboard`:
  - Holds the 31 counters and the issue/decrement/freeze logic.
  - Outputs `busy_vec`.
  - Top level holds the flush counter and the priority logic.

## Test plan
- Reset with `resetn`=0 mid-stream → all outputs 0, `busy_vec`=0.
- `addi x5` issues, then `add x6,x5,x1` is in ID (no FWD, `ALU_LAT`=3) → `stall_id`=1 and `bubble_ex`=1 for 3 cycles, `issue`=1 on the 4th; `busy_vec[5]` clears on the same cycle.
- `lw x7` issues, then a dependent instruction follows, with `HAZARD_FWD_EN` defined → exactly 1 bubble cycle. The same sequence with an ALU producer → 0 bubbles.
- `ex_redirect` pulses while a RAW hazard is pending → `flush_id`=1 for 2 cycles, `stall_id`=0, `issue`=0, and the scoreboard keeps decrementing.
- `mem_busy` held for 4 cycles during a pending hazard with counter=2 → counter still reads 2 when `mem_busy` drops, and `stall_if`=1 throughout.
- Instruction with `id_rd`=0 and `id_reg_write`=1 issues → `busy_vec` stays 0, and a following reader of x0 never stalls.
